darkbus_resp: RTL and testbench

Memory-mapped I/O responder on the darkriscv data bus, answering core accesses where DADDR[31]=1. It returns read data and a DHIT ready/handshake with a programmable number of wait states. It holds the board-info, LED/GPIO and timer registers, plus the timer interrupt request/acknowledge pair. It replaces the ad-hoc IOMUX/DACK logic at the SoC level with one self-contained block.

---
 rtl/darkbus_resp.sv | 163 ++++++++++++++++
 tb/tb_darkbus_resp.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/darkbus_resp.sv
// darkriscv MMIO responder: board info, LED/GPIO, timer and IRQ handshake behind DHIT wait states.
// Define DARKBUS_TICK_EN to turn word 1 into a free-running, write-to-clear tick counter.
module darkbus_resp #(
  parameter int unsigned WAITS      = 1,
  parameter logic [31:0] TIMER_INIT = 32'd99,
  parameter logic [7:0]  BOARD_ID   = 8'd0,
  parameter logic [7:0]  BOARD_CM   = 8'd100
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        RD,
  input  logic        WR,
  input  logic [3:0]  BE,
  input  logic [31:0] DADDR,
  input  logic [31:0] DATAI,
  output logic [31:0] DATAO,
  output logic        DHIT,
  output logic        IRQ,
  output logic [15:0] LED,
  output logic [15:0] GPIO
);

  localparam bit         NoWait   = (WAITS == 0);
  localparam logic [3:0] WaitLoad = NoWait ? 4'd0 : 4'(WAITS - 1);

  typedef enum logic [1:0] {StIdle, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        sel, commit, wr_en, iack_wr;
  logic [1:0]  widx;
  logic [31:0] rdata;
  logic [15:0] led_q, gpio_q;
  logic [31:0] timerff_q, timer_q;
  logic [7:0]  ireq_q, iack_q, irq_vec;
  logic        unused_addr;

  assign sel         = (RD | WR) & DADDR[31];
  assign widx        = DADDR[3:2];
  assign wr_en       = commit & WR & DADDR[31];
  assign iack_wr     = wr_en & (widx == 2'd0) & BE[3];
  assign irq_vec     = ireq_q ^ iack_q;
  assign IRQ         = |irq_vec;
  assign LED         = led_q;
  assign GPIO        = gpio_q;
  assign unused_addr = ^{DADDR[30:4], DADDR[1:0]};

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // DHIT stays high whenever nothing is selected, including an abandoned WAIT.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    DHIT    = ~sel;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (sel) begin
          if (NoWait) begin
            DHIT   = 1'b1;
            commit = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLoad;
          end
        end
      end
      StWait: begin
        if (!sel) begin
          state_d = StIdle;
        end else if (cnt_q == 4'd0) begin
          state_d = StAck;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StAck: begin
        DHIT    = 1'b1;
        commit  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef DARKBUS_TICK_EN
  logic [31:0] tick_q;

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      tick_q <= '0;
    end else if (wr_en && widx == 2'd1) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + 32'd1;
    end
  end
`endif

  always_comb begin
    rdata = '0;
    case (widx)
      2'd0: rdata = {irq_vec, 8'h00, BOARD_CM, BOARD_ID};
`ifdef DARKBUS_TICK_EN
      2'd1: rdata = tick_q;
`else
      2'd1: rdata = 32'd0;
`endif
      2'd2: rdata = {gpio_q, led_q};
      default: rdata = timerff_q;
    endcase
  end

  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      DATAO     <= '0;
      led_q     <= '0;
      gpio_q    <= '0;
      timerff_q <= TIMER_INIT;
    end else begin
      if (commit) DATAO <= rdata;
      if (wr_en && widx == 2'd2) begin
        for (int b = 0; b < 2; b++) begin
          if (BE[b])     led_q[8*b +: 8]  <= DATAI[8*b +: 8];
          if (BE[b + 2]) gpio_q[8*b +: 8] <= DATAI[8*(b + 2) +: 8];
        end
      end
      if (wr_en && widx == 2'd3) begin
        for (int b = 0; b < 4; b++) begin
          if (BE[b]) timerff_q[8*b +: 8] <= DATAI[8*b +: 8];
        end
      end
    end
  end

  // Reload only at underflow; IACK captures the pre-edge IREQ so a same-cycle toggle stays pending.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      timer_q <= '0;
      ireq_q  <= '0;
      iack_q  <= '0;
    end else begin
      if (timerff_q != '0) begin
        timer_q <= (timer_q != '0) ? timer_q - 32'd1 : timerff_q;
        if (timer_q == '0 && ireq_q == iack_q) ireq_q[7] <= ~iack_q[7];
      end
      if (iack_wr) begin
        for (int i = 0; i < 8; i++) begin
          if (DATAI[24 + i]) iack_q[i] <= ireq_q[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_darkbus_resp.sv
// Directed bench for darkbus_resp (WAITS=2): bus handshake, register map, timer/IRQ, abort and reset.
module tb_darkbus_resp;

  localparam int unsigned Waits = 2;

  logic        CLK = 1'b0;
  logic        RES, RD, WR;
  logic [3:0]  BE;
  logic [31:0] DADDR, DATAI;
  logic [31:0] DATAO;
  logic        DHIT, IRQ;
  logic [15:0] LED, GPIO;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  darkbus_resp #(
    .WAITS     (Waits),
    .TIMER_INIT(32'd99),
    .BOARD_ID  (8'd0),
    .BOARD_CM  (8'd100)
  ) u_dut (
    .CLK  (CLK),
    .RES  (RES),
    .RD   (RD),
    .WR   (WR),
    .BE   (BE),
    .DADDR(DADDR),
    .DATAI(DATAI),
    .DATAO(DATAO),
    .DHIT (DHIT),
    .IRQ  (IRQ),
    .LED  (LED),
    .GPIO (GPIO)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Entered 1ns after a rising edge; returns 1ns after the commit edge with the request dropped.
  task automatic bus_xfer(input logic wr, input logic [1:0] word, input logic [31:0] data,
                          input logic [3:0] be, output logic [31:0] rdata, output int low,
                          output int cedge);
    bit done = 1'b0;
    RD    = ~wr;
    WR    = wr;
    DADDR = 32'h8000_0000 | {28'h0, word, 2'b00};
    DATAI = data;
    BE    = be;
    low   = 0;
    cedge = -1;
    rdata = DATAO;
    for (int i = 0; i < 20 && !done; i++) begin
      #1;
      if (DHIT) begin
        @(posedge CLK);
        #1;
        cedge = cyc;
        rdata = DATAO;
        done  = 1'b1;
      end else begin
        low++;
        @(posedge CLK);
        #1;
      end
    end
    RD = 1'b0;
    WR = 1'b0;
    if (!done) check_eq("xfer_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_irq(input int budget, output int edge_no);
    edge_no = -1;
    for (int i = 0; i < budget && edge_no < 0; i++) begin
      if (IRQ) edge_no = cyc;
      else begin
        @(posedge CLK);
        #1;
      end
    end
    if (edge_no < 0) check_eq("irq_timeout", 32'd0, 32'd1);
  endtask

  logic [31:0] d;
  int low, ce, ce2, r_edge, e0, e1, exp_e;

  initial begin
    RES = 1'b0; RD = 1'b0; WR = 1'b0; BE = '0; DADDR = '0; DATAI = '0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("rst_datao", DATAO, 32'h0);
    check_eq("rst_dhit", {31'h0, DHIT}, 32'h1);
    check_eq("rst_led", {16'h0, LED}, 32'h0);
    check_eq("rst_gpio", {16'h0, GPIO}, 32'h0);
    check_eq("rst_irq", {31'h0, IRQ}, 32'h0);
    RES    = 1'b1;
    r_edge = cyc;

    // TIMER resets to 0, so the first edge underflows and raises IREQ[7].
    @(posedge CLK);
    #1;
    check_eq("irq_first_underflow", {31'h0, IRQ}, 32'h1);
    bus_xfer(1'b1, 2'd0, 32'h8000_0000, 4'b1000, d, low, ce);
    check_eq("ack_dhit_low", low, Waits + 1);
    check_eq("ack_irq_clear", {31'h0, IRQ}, 32'h0);
    bus_xfer(1'b0, 2'd0, 32'h0, 4'b0000, d, low, ce);
    check_eq("read_dhit_low", low, Waits + 1);
    check_eq("board_word", d, 32'h0000_6400);

    // Timer: TIMERFF=3 applies only at the next underflow (reload 99 at r_edge+1).
    bus_xfer(1'b1, 2'd3, 32'h0000_0003, 4'b1111, d, low, ce);
    bus_xfer(1'b0, 2'd3, 32'h0, 4'b0000, d, low, ce);
    check_eq("timerff_rb", d, 32'h3);
    wait_irq(200, e0);
    check_eq("no_reload_on_write", e0, r_edge + 101);
    bus_xfer(1'b1, 2'd0, 32'h8000_0000, 4'b1000, d, low, ce);
    check_eq("ack2_irq_clear", {31'h0, IRQ}, 32'h0);
    exp_e = e0 + 4;
    while (exp_e <= ce) exp_e += 4;
    wait_irq(20, e1);
    check_eq("timer_period4", e1, exp_e);

    // Back-to-back acks: the second commits on an underflow edge while nothing is pending.
    bus_xfer(1'b1, 2'd0, 32'h8000_0000, 4'b1000, d, low, ce);
    check_eq("ack3_irq_clear", {31'h0, IRQ}, 32'h0);
    bus_xfer(1'b1, 2'd0, 32'h8000_0000, 4'b1000, d, low, ce2);
    check_eq("ack4_on_underflow", ce2, e1 + 8);
    check_eq("ack_vs_toggle_pending", {31'h0, IRQ}, 32'h1);

    // TIMERFF=0 freezes the IRQ source.
    bus_xfer(1'b1, 2'd3, 32'h0, 4'b1111, d, low, ce);
    bus_xfer(1'b1, 2'd0, 32'h8000_0000, 4'b1000, d, low, ce);
    repeat (20) @(posedge CLK);
    #1;
    check_eq("frozen_no_irq", {31'h0, IRQ}, 32'h0);

    // LED/GPIO byte enables.
    bus_xfer(1'b1, 2'd2, 32'hABCD_1234, 4'b0011, d, low, ce);
    check_eq("led_lo_bytes", {16'h0, LED}, 32'h1234);
    check_eq("gpio_untouched", {16'h0, GPIO}, 32'h0);
    bus_xfer(1'b1, 2'd2, 32'hABCD_1234, 4'b1100, d, low, ce);
    check_eq("gpio_hi_bytes", {16'h0, GPIO}, 32'hABCD);
    check_eq("led_kept", {16'h0, LED}, 32'h1234);
    bus_xfer(1'b0, 2'd2, 32'h0, 4'b0000, d, low, ce);
    check_eq("word2_rb", d, 32'hABCD_1234);

`ifdef DARKBUS_TICK_EN
    begin
      logic [31:0] t1, t2;
      int c1, c2, cw;
      bus_xfer(1'b0, 2'd1, 32'h0, 4'b0000, t1, low, c1);
      repeat (10) @(posedge CLK);
      #1;
      bus_xfer(1'b0, 2'd1, 32'h0, 4'b0000, t2, low, c2);
      check_eq("tick_delta", t2 - t1, c2 - c1);
      bus_xfer(1'b1, 2'd1, 32'hFFFF_FFFF, 4'b0000, d, low, cw);
      bus_xfer(1'b0, 2'd1, 32'h0, 4'b0000, t1, low, c1);
      check_eq("tick_after_clear", t1, c1 - cw - 1);
    end
`else
    bus_xfer(1'b1, 2'd1, 32'hFFFF_FFFF, 4'b1111, d, low, ce);
    bus_xfer(1'b0, 2'd1, 32'h0, 4'b0000, d, low, ce);
    check_eq("word1_zero", d, 32'h0);
`endif

    // Abort a read, then a write, during WAIT.
    bus_xfer(1'b0, 2'd0, 32'h0, 4'b0000, d, low, ce);
    check_eq("board_before_abort", d, 32'h0000_6400);
    RD = 1'b1; WR = 1'b0; DADDR = 32'h8000_0008; BE = '0;
    @(posedge CLK);
    #1;
    RD = 1'b0;
    #1;
    check_eq("abort_dhit", {31'h0, DHIT}, 32'h1);
    repeat (3) @(posedge CLK);
    #1;
    check_eq("abort_rd_datao", DATAO, 32'h0000_6400);
    RD = 1'b0; WR = 1'b1; DADDR = 32'h8000_0008; DATAI = 32'h0000_5555; BE = 4'b0011;
    @(posedge CLK);
    #1;
    WR = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("abort_wr_led", {16'h0, LED}, 32'h1234);
    bus_xfer(1'b0, 2'd2, 32'h0, 4'b0000, d, low, ce);
    check_eq("idle_after_abort", low, Waits + 1);
    check_eq("word2_after_abort", d, 32'hABCD_1234);

    // Reset in the middle of a LED write.
    RD = 1'b0; WR = 1'b1; DADDR = 32'h8000_0008; DATAI = 32'h0000_7777; BE = 4'b0011;
    @(posedge CLK);
    #1;
    RES = 1'b0; WR = 1'b0;
    #1;
    check_eq("midrst_led", {16'h0, LED}, 32'h0);
    check_eq("midrst_dhit", {31'h0, DHIT}, 32'h1);
    @(posedge CLK);
    #1;
    RES = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check_eq("midrst_led_after", {16'h0, LED}, 32'h0);
    bus_xfer(1'b0, 2'd3, 32'h0, 4'b0000, d, low, ce);
    check_eq("midrst_timerff", d, 32'd99);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
